// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin-operated vending controller: credit, selection, dispense and change
module vend_controller #(
    parameter int PRICE_A = 15,
    parameter int PRICE_B = 20,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       sel_valid,
    input  logic       sel_id,
    input  logic       cancel,
    output logic       disp_req,
    output logic       disp_id,
    input  logic       disp_ack,
    output logic       chg_req,
    input  logic       chg_ack,
    output logic [5:0] credit,
    output logic       busy,
    output logic       coin_rej,
    output logic       err_low
);

    localparam logic [5:0] PRICE_A_C   = 6'(PRICE_A);
    localparam logic [5:0] PRICE_B_C   = 6'(PRICE_B);
    localparam logic [7:0] TIMEOUT_END = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] credit_nxt;
    logic [7:0] timer, timer_nxt;
    logic       disp_id_nxt;
    logic       coin_rej_nxt;
    logic       err_low_nxt;

    logic [5:0] coin_val;
    logic [6:0] coin_total;
    logic       coins_fit;
    logic [5:0] coin_acc;
    logic [5:0] credit_acc;
    logic [5:0] price;
    logic       any_coin;

    // Value of this cycle's coins and whether they fit without exceeding 63
    always_comb begin
        any_coin   = coin5 | coin10;
        coin_val   = (coin5 ? 6'd5 : 6'd0) + (coin10 ? 6'd10 : 6'd0);
        coin_total = {1'b0, credit} + {1'b0, coin_val};
        coins_fit  = ~coin_total[6];
        coin_acc   = coins_fit ? coin_val : 6'd0;
        credit_acc = credit + coin_acc;
        price      = sel_id ? PRICE_B_C : PRICE_A_C;
    end

    // Next-state and next-register logic; cancel outranks selection, selection outranks timeout
    always_comb begin
        state_nxt    = state;
        credit_nxt   = credit;
        timer_nxt    = 8'd0;
        disp_id_nxt  = disp_id;
        coin_rej_nxt = 1'b0;
        err_low_nxt  = 1'b0;
        case (state)
            S_IDLE, S_COLLECT: begin
                coin_rej_nxt = any_coin & ~coins_fit;
                if (cancel) begin
                    credit_nxt = credit_acc;
                    state_nxt  = (credit_acc != 6'd0) ? S_CHANGE : S_IDLE;
                end else if (sel_valid) begin
                    if (credit >= price) begin
                        credit_nxt  = credit_acc - price;
                        disp_id_nxt = sel_id;
                        state_nxt   = S_DISPENSE;
                    end else begin
                        err_low_nxt = 1'b1;
                        credit_nxt  = credit_acc;
                        if (coin_acc != 6'd0) begin
                            state_nxt = S_COLLECT;
                        end
                    end
                end else if (coin_acc != 6'd0) begin
                    credit_nxt = credit_acc;
                    state_nxt  = S_COLLECT;
                end else if (state == S_COLLECT) begin
                    if (timer == TIMEOUT_END) begin
                        state_nxt = (credit != 6'd0) ? S_CHANGE : S_IDLE;
                    end else begin
                        timer_nxt = timer + 8'd1;
                    end
                end
            end
            S_DISPENSE: begin
                coin_rej_nxt = any_coin;
                if (disp_ack) begin
                    state_nxt = (credit != 6'd0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: begin
                coin_rej_nxt = any_coin;
                if (credit == 6'd0) begin
                    state_nxt = S_IDLE;
                end else if (chg_ack) begin
                    credit_nxt = credit - 6'd5;
                    if (credit == 6'd5) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any pending transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            credit   <= 6'd0;
            timer    <= 8'd0;
            disp_id  <= 1'b0;
            coin_rej <= 1'b0;
            err_low  <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            timer    <= timer_nxt;
            disp_id  <= disp_id_nxt;
            coin_rej <= coin_rej_nxt;
            err_low  <= err_low_nxt;
        end
    end

    // Handshake requests and busy flag follow directly from the registered state
    always_comb begin
        disp_req = (state == S_DISPENSE);
        chg_req  = (state == S_CHANGE) && (credit != 6'd0);
        busy     = (state == S_DISPENSE) || (state == S_CHANGE);
    end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter PRICE_A, default 15, price of product 0 in credit units; SHALL be a multiple of 5, 5..60.
REQ-002 Parameter PRICE_B, default 20, price of product 1; same constraints as PRICE_A.
REQ-003 Parameter TIMEOUT, default 255, idle cycles in COLLECT before automatic refund; range 1..255.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 coin5  input  1  single-cycle pulse, 5-unit coin inserted.
REQ-007 coin10  input  1  single-cycle pulse, 10-unit coin inserted.
REQ-008 sel_valid  input  1  single-cycle pulse, product selection.
REQ-009 sel_id  input  1  product index, qualified by sel_valid (0 -> PRICE_A, 1 -> PRICE_B).
REQ-010 cancel  input  1  single-cycle pulse, refund request.
REQ-011 disp_req  output  1  dispense request to motor, held until acknowledged.
REQ-012 disp_id  output  1  product to dispense, stable while disp_req high.
REQ-013 disp_ack  input  1  motor acknowledge, sampled only while disp_req high.
REQ-014 chg_req  output  1  request to eject one 5-unit coin.
REQ-015 chg_ack  input  1  coin-eject acknowledge, sampled only while chg_req high.
REQ-016 credit  output  6  current credit, registered.
REQ-017 busy  output  1  high in DISPENSE or CHANGE.
REQ-018 coin_rej  output  1  one-cycle pulse, coin(s) not accepted this cycle.
REQ-019 err_low  output  1  one-cycle pulse, selection with insufficient credit.

Function
REQ-020 States IDLE, COLLECT, DISPENSE, CHANGE; busy = (state==DISPENSE || state==CHANGE).
REQ-021 IDLE/COLLECT: coins add 5/10 (both same cycle add 15); any accepted coin -> COLLECT.
REQ-022 Coins whose sum makes credit exceed 63: all coins that cycle rejected, credit unchanged, coin_rej pulses next cycle.
REQ-023 Coins in DISPENSE or CHANGE: rejected, coin_rej pulses, credit unchanged.
REQ-024 Priority in IDLE/COLLECT: cancel > sel_valid > timeout; accepted same-cycle coins are always added.
REQ-025 cancel with credit+accepted coins > 0 -> CHANGE; with total 0 -> IDLE, no other effect.
REQ-026 sel_valid: price compared against registered credit only (same-cycle coins excluded from comparison).
REQ-027 credit >= price: next credit = credit + accepted coins - price; disp_id <= sel_id; disp_req high from next cycle; -> DISPENSE.
REQ-028 credit < price: err_low pulses next cycle; coins still added; state unchanged apart from IDLE->COLLECT on coin.
REQ-029 COLLECT timer: clears on any accepted coin or sel_valid; increments otherwise; at TIMEOUT -> CHANGE.
REQ-030 DISPENSE: disp_req held until disp_ack sampled high; next cycle disp_req low, -> CHANGE if credit > 0, else IDLE.
REQ-031 CHANGE: chg_req high while credit > 0; each cycle chg_ack is sampled high, credit -= 5.
REQ-032 CHANGE: ack taking credit to 0 -> chg_req low and state IDLE next cycle; back-to-back acks legal, one coin each.
REQ-033 disp_ack outside DISPENSE and chg_ack outside CHANGE SHALL be ignored.
REQ-034 Credit always a multiple of 5; no wrap-around, no underflow.

Reset
REQ-035 reset SHALL, in any state, force IDLE, credit=0, timer=0, disp_req=0, disp_id=0, chg_req=0, coin_rej=0, err_low=0, busy=0 on the next edge.
REQ-036 Reset mid-DISPENSE or mid-CHANGE SHALL abandon the transaction; pending credit is discarded, not refunded.
REQ-037 Inputs SHALL be ignored during the reset cycle.

Verification
REQ-038 coin10, coin5, sel_valid id0 (PRICE_A=15) -> credit 15 -> 0, disp_req until ack, then IDLE, no chg_req.
REQ-039 coin10 x2, sel id1 (20)... credit 20 -> 0; then coin10 x3, sel id0 -> credit 30 -> 15, dispense, chg_req for 3 acks, credit 0, IDLE.
REQ-040 coin5, sel id1 -> err_low one cycle, credit 5 kept; then cancel -> one chg_ack returns credit 0, IDLE.
REQ-041 coin10 x6 then coin5 -> credit 60; coin10 -> coin_rej, credit 60; coin5 -> credit stays 60 for coin5+coin10 together (rejected); coin5 alone -> 60+... rejected (65>63), coin_rej.
REQ-042 coin5 then no activity TIMEOUT=4 cycles -> CHANGE, one chg_ack -> IDLE; coin during CHANGE -> coin_rej.
REQ-043 Reset asserted while disp_req high -> next cycle all outputs 0, state IDLE, credit 0; late disp_ack ignored.
